// File: rtl/pong_pkg.sv
// Shared types and constants for the LED ping-pong game controller.
package pong_pkg;

  typedef enum logic [2:0] {IDLE, SERVE, MOVE_R, MOVE_L, POINT, OVER} state_t;
  typedef enum logic {LEFT, RIGHT} side_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;

  function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
    return (s >= lim) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Move-tick prescaler: single-cycle o_tick every i_div enabled cycles; i_clr restarts the count.
module pong_tick_gen (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_div,
  output logic        o_tick
);

  logic [31:0] r_cnt;

  // >= keeps the prescaler from running away if the divider shrinks mid-count
  assign o_tick = i_en && (r_cnt >= i_div - 32'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/pong_ctrl.sv
// LED ping-pong game controller: ball sequencing, hit/miss/fault judging, scores.
// Optional build macro PONG_SPEEDUP_EN shortens the move period on every return.
module pong_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned N_LEDS      = 8,
  parameter int unsigned TICK_DIV    = 25000000,
  parameter int unsigned WIN_SCORE   = 11,
  parameter int unsigned POINT_TICKS = 4,
  parameter int unsigned SPEED_STEP  = 2000000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn_l,
  input  logic              btn_r,
  output logic [N_LEDS-1:0] leds,
  output logic [3:0]        score_l,
  output logic [3:0]        score_r,
  output logic [1:0]        winner,
  output logic              busy
);

  localparam int unsigned   PW      = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0] POS_R   = PW'(N_LEDS - 1);
  localparam logic [3:0]    WIN     = 4'(WIN_SCORE);
  localparam logic [15:0]   PT_LAST = 16'(POINT_TICKS - 1);

  if (TICK_DIV < 4 || WIN_SCORE < 1 || WIN_SCORE > 15 || SPEED_STEP >= TICK_DIV) begin : g_bad_cfg
    $error("pong_ctrl: invalid parameter set");
  end

  state_t        r_state,   w_state_nxt;
  side_t         r_server,  w_server_nxt;
  logic [PW-1:0] r_pos,     w_pos_nxt;
  logic [3:0]    r_score_l, w_score_l_nxt;
  logic [3:0]    r_score_r, w_score_r_nxt;
  logic [1:0]    r_winner,  w_winner_nxt;
  logic [15:0]   r_pt_cnt,  w_pt_cnt_nxt;
  logic          w_tick, w_en, w_clr;
  logic [31:0]   w_div;

  assign w_en  = (r_state == MOVE_R) || (r_state == MOVE_L) || (r_state == POINT);
  assign w_clr = (w_state_nxt != r_state);

  pong_tick_gen u_tick (
    .i_clk  (CLK),
    .i_rst  (RST),
    .i_clr  (w_clr),
    .i_en   (w_en),
    .i_div  (w_div),
    .o_tick (w_tick)
  );

`ifdef PONG_SPEEDUP_EN
  localparam logic [31:0] DIV_MAX = 32'(TICK_DIV);
  localparam logic [31:0] DIV_MIN = 32'(TICK_DIV / 4);
  localparam logic [31:0] STEP    = 32'(SPEED_STEP);

  logic [31:0] r_div;
  logic        w_hit;

  assign w_hit = ((r_state == MOVE_R) && btn_r && (r_pos == POS_R)) ||
                 ((r_state == MOVE_L) && btn_l && (r_pos == '0));

  always_ff @(posedge CLK) begin
    if (RST || r_state == IDLE || (w_state_nxt == SERVE && r_state != SERVE)) begin
      r_div <= DIV_MAX;
    end else if (w_hit) begin
      r_div <= (r_div >= DIV_MIN + STEP) ? r_div - STEP : DIV_MIN;
    end
  end

  assign w_div = r_div;
`else
  assign w_div = 32'(TICK_DIV);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_server_nxt  = r_server;
    w_pos_nxt     = r_pos;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;
    w_winner_nxt  = r_winner;
    w_pt_cnt_nxt  = r_pt_cnt;
    case (r_state)
      IDLE, SERVE: begin
        if (btn_l && (r_state == IDLE || r_server == LEFT)) begin
          w_state_nxt = MOVE_R;
          w_pos_nxt   = '0;
        end else if (btn_r && (r_state == IDLE || r_server == RIGHT)) begin
          w_state_nxt = MOVE_L;
          w_pos_nxt   = POS_R;
        end
      end
      // A button at the far end beats a coincident tick; elsewhere it is a fault.
      MOVE_R: begin
        if (btn_r && r_pos == POS_R) begin
          w_state_nxt = MOVE_L;
        end else if (btn_r || (w_tick && r_pos == POS_R)) begin
          w_score_l_nxt = sat_inc(r_score_l, WIN);
          w_server_nxt  = RIGHT;
          w_pt_cnt_nxt  = '0;
          w_state_nxt   = POINT;
        end else if (w_tick) begin
          w_pos_nxt = r_pos + PW'(1);
        end
      end
      MOVE_L: begin
        if (btn_l && r_pos == '0) begin
          w_state_nxt = MOVE_R;
        end else if (btn_l || (w_tick && r_pos == '0)) begin
          w_score_r_nxt = sat_inc(r_score_r, WIN);
          w_server_nxt  = LEFT;
          w_pt_cnt_nxt  = '0;
          w_state_nxt   = POINT;
        end else if (w_tick) begin
          w_pos_nxt = r_pos - PW'(1);
        end
      end
      POINT: begin
        if (w_tick) begin
          w_pt_cnt_nxt = r_pt_cnt + 16'd1;
          if (r_pt_cnt == PT_LAST) begin
            if (r_score_l == WIN || r_score_r == WIN) begin
              w_state_nxt  = OVER;
              w_winner_nxt = (r_score_l == WIN) ? WIN_L : WIN_R;
            end else begin
              w_state_nxt = SERVE;
            end
          end
        end
      end
      OVER: begin
        if (btn_l || btn_r) begin
          w_state_nxt   = IDLE;
          w_score_l_nxt = '0;
          w_score_r_nxt = '0;
          w_winner_nxt  = WIN_NONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_server  <= LEFT;
      r_pos     <= '0;
      r_score_l <= '0;
      r_score_r <= '0;
      r_winner  <= WIN_NONE;
      r_pt_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_server  <= w_server_nxt;
      r_pos     <= w_pos_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
      r_winner  <= w_winner_nxt;
      r_pt_cnt  <= w_pt_cnt_nxt;
    end
  end

  always_comb begin
    leds = '0;
    case (r_state)
      SERVE: begin
        if (r_server == LEFT) leds[0] = 1'b1;
        else                  leds[N_LEDS-1] = 1'b1;
      end
      MOVE_R, MOVE_L: leds[r_pos] = 1'b1;
      POINT:          leds = r_pt_cnt[0] ? '0 : '1;
      OVER: begin
        for (int unsigned i = 0; i < N_LEDS; i++) begin
          leds[i] = (r_winner == WIN_L) ? (i < N_LEDS / 2) : (i >= N_LEDS / 2);
        end
      end
      default: leds = '0;
    endcase
  end

  assign score_l = r_score_l;
  assign score_r = r_score_r;
  assign winner  = r_winner;
  assign busy    = (r_state != IDLE) && (r_state != OVER);

endmodule

// File: tb/tb_pong_ctrl.sv
// Self-checking bench for pong_ctrl: directed game script plus random button traffic vs a rally-level model.
module tb_pong_ctrl;

  localparam int N    = 8;
  localparam int TD   = 4;
  localparam int WS   = 3;
  localparam int PT   = 2;
  localparam int STEP = 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         btn_l = 1'b0;
  logic         btn_r = 1'b0;
  logic [N-1:0] leds;
  logic [3:0]   score_l, score_r;
  logic [1:0]   winner;
  logic         busy;

  int vectors = 0;
  int errors  = 0;
  bit checking = 1'b0;

  always #5 CLK = ~CLK;

  pong_ctrl #(
    .N_LEDS      (N),
    .TICK_DIV    (TD),
    .WIN_SCORE   (WS),
    .POINT_TICKS (PT),
    .SPEED_STEP  (STEP)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .leds    (leds),
    .score_l (score_l),
    .score_r (score_r),
    .winner  (winner),
    .busy    (busy)
  );

  // Model: phase 0 idle, 1 serve, 2 ball in flight, 3 point flash, 4 game over.
  int m_phase = 0, m_dir = 1, m_pos = 0, m_cnt = 0, m_fl = 0;
  int m_sl = 0, m_sr = 0, m_srv = 0, m_div = TD, m_win = 0;

  task automatic launch(input int d);
    m_phase = 2;
    m_dir   = d;
    m_pos   = (d > 0) ? 0 : N - 1;
    m_cnt   = 0;
  endtask

  task automatic award(input int to_right);
    if (to_right != 0) begin
      m_sr  = (m_sr < WS) ? m_sr + 1 : WS;
      m_srv = 0;
    end else begin
      m_sl  = (m_sl < WS) ? m_sl + 1 : WS;
      m_srv = 1;
    end
    m_phase = 3;
    m_fl    = 0;
    m_cnt   = 0;
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      m_phase = 0; m_dir = 1; m_pos = 0; m_cnt = 0; m_fl = 0;
      m_sl = 0; m_sr = 0; m_srv = 0; m_div = TD; m_win = 0;
    end else begin
      int  far_end;
      bit  hitter, tick;
      if (m_phase == 0) m_div = TD;
      case (m_phase)
        0: if (btn_l) launch(1); else if (btn_r) launch(-1);
        1: if (m_srv == 0 && btn_l) launch(1); else if (m_srv == 1 && btn_r) launch(-1);
        2: begin
          hitter  = (m_dir > 0) ? btn_r : btn_l;
          far_end = (m_dir > 0) ? N - 1 : 0;
          tick    = (m_cnt == m_div - 1);
          if (hitter && m_pos == far_end) begin
            m_dir = -m_dir;
            m_cnt = 0;
`ifdef PONG_SPEEDUP_EN
            m_div = (m_div - STEP >= TD / 4) ? m_div - STEP : TD / 4;
`endif
          end else if (hitter || (tick && m_pos == far_end)) begin
            award((m_dir > 0) ? 0 : 1);
          end else if (tick) begin
            m_pos = m_pos + m_dir;
            m_cnt = 0;
          end else begin
            m_cnt++;
          end
        end
        3: begin
          if (m_cnt == m_div - 1) begin
            m_cnt = 0;
            m_fl++;
            if (m_fl == PT) begin
              if (m_sl == WS || m_sr == WS) begin
                m_phase = 4;
                m_win   = (m_sl == WS) ? 1 : 2;
              end else begin
                m_phase = 1;
                m_div   = TD;
              end
            end
          end else begin
            m_cnt++;
          end
        end
        default: if (btn_l || btn_r) begin
          m_phase = 0; m_sl = 0; m_sr = 0; m_win = 0;
        end
      endcase
    end
  end

  function automatic logic [N-1:0] exp_leds();
    int half;
    half = (1 << (N / 2)) - 1;
    case (m_phase)
      1:       return (m_srv == 0) ? N'(1) : N'(1 << (N - 1));
      2:       return N'(1 << m_pos);
      3:       return (m_fl % 2 == 0) ? '1 : '0;
      4:       return (m_win == 1) ? N'(half) : N'(half << (N / 2));
      default: return '0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (checking) begin
      logic [N-1:0] el;
      logic         eb;
      el = exp_leds();
      eb = (m_phase >= 1 && m_phase <= 3);
      vectors++;
      if (leds !== el || score_l !== 4'(m_sl) || score_r !== 4'(m_sr) ||
          winner !== 2'(m_win) || busy !== eb) begin
        errors++;
        $display("FAIL model_cmp t=%0t got leds=%h sl=%0d sr=%0d win=%0d busy=%0b, exp leds=%h sl=%0d sr=%0d win=%0d busy=%0b",
                 $time, leds, score_l, score_r, winner, busy, el, m_sl, m_sr, m_win, eb);
      end
    end
  end

  task automatic pin(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic press(input bit l, input bit r);
    btn_l = l;
    btn_r = r;
    @(negedge CLK);
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic wait_leds(input string name, input logic [N-1:0] v, input int bound);
    int k = 0;
    while (leds !== v && k < bound) begin
      @(negedge CLK);
      k++;
    end
    pin(name, 32'(leds), 32'(v));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    checking = 1'b1;
    pin("rst_leds", 32'(leds), 32'h0);
    pin("rst_busy", 32'(busy), 32'h0);
    pin("rst_win", 32'(winner), 32'h0);
    RST = 1'b0;
    @(negedge CLK);

    // Left serve, no return
    press(1, 0);
    pin("serve_l_leds", 32'(leds), 32'h01);
    pin("serve_l_busy", 32'(busy), 32'h1);
    repeat (28) @(negedge CLK);
    pin("walk_80", 32'(leds), 32'h80);
    repeat (4) @(negedge CLK);
    pin("miss_score_l", 32'(score_l), 32'h1);
    pin("flash_on", 32'(leds), 32'hFF);
    repeat (4) @(negedge CLK);
    pin("flash_off", 32'(leds), 32'h00);
    repeat (4) @(negedge CLK);
    pin("serve_r_leds", 32'(leds), 32'h80);

    // Rally, then early fault
    press(0, 1);
    pin("launch_l", 32'(leds), 32'h80);
    repeat (28) @(negedge CLK);
    pin("walk_01", 32'(leds), 32'h01);
    press(1, 0);
    pin("return_leds", 32'(leds), 32'h01);
    pin("return_score", 32'({score_l, score_r}), 32'h10);
    repeat (3) @(negedge CLK);
`ifdef PONG_SPEEDUP_EN
    pin("post_hit_step", 32'(leds), 32'h02);
`else
    pin("post_hit_step", 32'(leds), 32'h01);
`endif
    wait_leds("reach_08", 8'h08, 40);
    press(0, 1);
    pin("fault_score_l", 32'(score_l), 32'h2);
    pin("fault_flash", 32'(leds), 32'hFF);

    // Tick/hit coincidence at the right end
    wait_leds("serve_r2", 8'h80, 20);
    press(0, 1);
    wait_leds("reach_01", 8'h01, 40);
    press(1, 0);
    wait_leds("reach_80", 8'h80, 40);
    repeat (m_div - 1) @(negedge CLK);
    press(0, 1);
    pin("coinc_leds", 32'(leds), 32'h80);
    pin("coinc_score", 32'({score_l, score_r}), 32'h20);

    // Left misses, left serves, right misses -> game over
    begin
      int k = 0;
      while (score_r !== 4'd1 && k < 100) begin @(negedge CLK); k++; end
      pin("left_miss", 32'(score_r), 32'h1);
    end
    wait_leds("serve_l2", 8'h01, 20);
    press(1, 0);
    begin
      int k = 0;
      while (winner === 2'b00 && k < 200) begin @(negedge CLK); k++; end
    end
    pin("over_winner", 32'(winner), 32'h1);
    pin("over_leds", 32'(leds), 32'h0F);
    pin("over_busy", 32'(busy), 32'h0);
    press(0, 1);
    pin("clear_scores", 32'({score_l, score_r}), 32'h00);
    pin("clear_winner", 32'(winner), 32'h0);

    // Reset mid-rally with a nonzero score
    press(1, 0);
    press(0, 1);
    wait_leds("serve_r3", 8'h80, 20);
    press(0, 1);
    repeat (6) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    pin("midrst_leds", 32'(leds), 32'h0);
    pin("midrst_score", 32'(score_l), 32'h0);
    pin("midrst_busy", 32'(busy), 32'h0);

    // Simultaneous start: left takes priority
    press(1, 1);
    pin("both_start", 32'(leds), 32'h01);

    // Random button traffic with occasional reset
    for (int i = 0; i < 4000; i++) begin
      btn_l = ($urandom_range(0, 9) == 0);
      btn_r = ($urandom_range(0, 9) == 0);
      RST   = ($urandom_range(0, 699) == 0);
      @(negedge CLK);
    end
    btn_l = 1'b0;
    btn_r = 1'b0;
    RST   = 1'b0;
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
